// File: rtl/console_tx_region_pkg.sv
// Shared types and register map for the console TX region.
// Optional 8E1 framing is enabled by defining CONSOLE_PARITY_EN.
package console_tx_region_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } console_state_e;

   localparam logic [3:0] CONSOLE_TXDATA  = 4'h0;
   localparam logic [3:0] CONSOLE_STATUS  = 4'h4;
   localparam logic [3:0] CONSOLE_BAUDDIV = 4'h8;

   localparam int unsigned STATUS_FULL_BIT  = 0;
   localparam int unsigned STATUS_EMPTY_BIT = 1;
   localparam int unsigned STATUS_BUSY_BIT  = 2;
   localparam int unsigned STATUS_OVF_BIT   = 3;
   localparam int unsigned STATUS_COUNT_LSB = 8;

   // A divider of zero would stall the serialiser, so it is stored as one.
   function automatic logic [15:0] sanitizeDiv(input logic [15:0] d);
      return (d == 16'd0) ? 16'd1 : d;
   endfunction

endpackage

// File: rtl/console_tx_serializer.sv
// UART transmit serialiser: start, 8 data bits LSB first, optional even parity
// (CONSOLE_PARITY_EN), stop. Accepts a new byte in IDLE or on the last STOP cycle.
module console_tx_serializer
   import console_tx_region_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        byteValid,
   input  logic [7:0]  byteData,
   input  logic [15:0] baudDiv,
   output logic        byteReady,
   output logic        tx,
   output logic        busy
);

   console_state_e state, stateNext;
   logic [15:0] baudCnt, baudCntNext;
   logic [15:0] divLat, divLatNext;
   logic [2:0]  bitCnt, bitCntNext;
   logic [7:0]  shiftReg, shiftNext;
   logic        txReg, txNext;
   logic        bitEnd;
   logic        load;
`ifdef CONSOLE_PARITY_EN
   logic        parityBit, parityNext;
`endif

   assign bitEnd    = (baudCnt == 16'd0);
   assign byteReady = (state == IDLE) || ((state == STOP) && bitEnd);
   assign load      = byteValid && byteReady;
   assign tx        = txReg;
   assign busy      = (state != IDLE);

   // Next-state, counters and registered line level; a load overrides everything.
   always_comb begin
      stateNext   = state;
      baudCntNext = bitEnd ? 16'd0 : baudCnt - 16'd1;
      divLatNext  = divLat;
      bitCntNext  = bitCnt;
      shiftNext   = shiftReg;
      txNext      = txReg;
`ifdef CONSOLE_PARITY_EN
      parityNext  = parityBit;
`endif
      case (state)
         IDLE: txNext = 1'b1;
         START: if (bitEnd) begin
            stateNext   = DATA;
            txNext      = shiftReg[0];
            baudCntNext = divLat - 16'd1;
            bitCntNext  = 3'd0;
         end
         DATA: if (bitEnd) begin
            baudCntNext = divLat - 16'd1;
            if (bitCnt == 3'd7) begin
`ifdef CONSOLE_PARITY_EN
               stateNext = PARITY;
               txNext    = parityBit;
`else
               stateNext = STOP;
               txNext    = 1'b1;
`endif
            end else begin
               shiftNext  = {1'b0, shiftReg[7:1]};
               txNext     = shiftReg[1];
               bitCntNext = bitCnt + 3'd1;
            end
         end
         PARITY: if (bitEnd) begin
            stateNext   = STOP;
            txNext      = 1'b1;
            baudCntNext = divLat - 16'd1;
         end
         STOP: if (bitEnd) begin
            stateNext = IDLE;
            txNext    = 1'b1;
         end
         default: begin
            stateNext = IDLE;
            txNext    = 1'b1;
         end
      endcase
      if (load) begin
         stateNext   = START;
         txNext      = 1'b0;
         shiftNext   = byteData;
         divLatNext  = baudDiv;
         baudCntNext = baudDiv - 16'd1;
         bitCntNext  = 3'd0;
`ifdef CONSOLE_PARITY_EN
         parityNext  = ^byteData;
`endif
      end
   end

   // State registers; reset aborts any frame and forces the line high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         baudCnt  <= '0;
         divLat   <= 16'd1;
         bitCnt   <= '0;
         shiftReg <= '0;
         txReg    <= 1'b1;
`ifdef CONSOLE_PARITY_EN
         parityBit <= 1'b0;
`endif
      end else begin
         state    <= stateNext;
         baudCnt  <= baudCntNext;
         divLat   <= divLatNext;
         bitCnt   <= bitCntNext;
         shiftReg <= shiftNext;
         txReg    <= txNext;
`ifdef CONSOLE_PARITY_EN
         parityBit <= parityNext;
`endif
      end
   end

endmodule

// File: rtl/console_tx_region.sv
// Memory-mapped console: TX FIFO, register decode and sticky overflow flag,
// feeding console_tx_serializer. Define CONSOLE_PARITY_EN for 8E1 frames.
module console_tx_region
   import console_tx_region_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH     = 16,
   parameter logic [15:0] BAUD_DIV_RESET = 16'd434
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        bus_sel,
   input  logic        bus_we,
   input  logic [3:0]  bus_addr,
   input  logic [31:0] bus_wdata,
   output logic [31:0] bus_rdata,
   output logic        tx_o,
   output logic        tx_busy_o
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] DEPTH_CNT = FIFO_DEPTH[PW:0];

   logic [7:0]    fifoMem [FIFO_DEPTH];
   logic [PW-1:0] wrPtr, rdPtr;
   logic [PW:0]   count;
   logic          overflow;
   logic [15:0]   baudDiv;
   logic [3:0]    regOff;
   logic          wrTx, wrStatus, wrBaud;
   logic          full, empty, doPush, doPop, popReady;
   logic          unusedBits;

   assign regOff   = {bus_addr[3:2], 2'b00};
   assign wrTx     = bus_sel && bus_we && (regOff == CONSOLE_TXDATA);
   assign wrStatus = bus_sel && bus_we && (regOff == CONSOLE_STATUS);
   assign wrBaud   = bus_sel && bus_we && (regOff == CONSOLE_BAUDDIV);
   assign full     = (count == DEPTH_CNT);
   assign empty    = (count == '0);
   assign doPush   = wrTx && !full;
   assign doPop    = popReady && !empty;
   assign unusedBits = ^{bus_addr[1:0], bus_wdata[31:16]};

   // FIFO storage needs no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (doPush) fifoMem[wrPtr] <= bus_wdata[7:0];
   end

   // Pointers, count, overflow flag and divider register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wrPtr    <= '0;
         rdPtr    <= '0;
         count    <= '0;
         overflow <= 1'b0;
         baudDiv  <= BAUD_DIV_RESET;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
         if (doPush && !doPop)      count <= count + 1'b1;
         else if (doPop && !doPush) count <= count - 1'b1;
         if (wrTx && full)                                overflow <= 1'b1;
         else if (wrStatus && bus_wdata[STATUS_OVF_BIT]) overflow <= 1'b0;
         if (wrBaud) baudDiv <= sanitizeDiv(bus_wdata[15:0]);
      end
   end

   // Combinational read mux; zero when the region is not selected.
   always_comb begin
      bus_rdata = '0;
      if (bus_sel) begin
         case (regOff)
            CONSOLE_STATUS: begin
               bus_rdata[STATUS_FULL_BIT]  = full;
               bus_rdata[STATUS_EMPTY_BIT] = empty;
               bus_rdata[STATUS_BUSY_BIT]  = tx_busy_o;
               bus_rdata[STATUS_OVF_BIT]   = overflow;
               bus_rdata[STATUS_COUNT_LSB +: PW+1] = count;
            end
            CONSOLE_BAUDDIV: bus_rdata[15:0] = baudDiv;
            default: bus_rdata = '0;
         endcase
      end
   end

   console_tx_serializer u_ser (
      .clk       (clk),
      .rst_n     (reset),
      .byteValid (!empty),
      .byteData  (fifoMem[rdPtr]),
      .baudDiv   (baudDiv),
      .byteReady (popReady),
      .tx        (tx_o),
      .busy      (tx_busy_o)
   );

endmodule

// File: tb/tb_console_tx_region.sv
// Directed self-checking bench for console_tx_region.
module tb_console_tx_region;

   logic        clk = 1'b0;
   logic        reset;
   logic        bus_sel, bus_we;
   logic [3:0]  bus_addr;
   logic [31:0] bus_wdata, bus_rdata;
   logic        tx_o, tx_busy_o;

   int total = 0;
   int bad   = 0;
   logic expQ[$];

`ifdef CONSOLE_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif

   console_tx_region #(.FIFO_DEPTH(16), .BAUD_DIV_RESET(16'd434)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus_sel   (bus_sel),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_rdata (bus_rdata),
      .tx_o      (tx_o),
      .tx_busy_o (tx_busy_o)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic busWrite(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      bus_sel = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
      @(posedge clk); #1;
      bus_sel = 1'b0; bus_we = 1'b0;
   endtask

   // Samples within the low phase; crosses no rising edge when called right after busWrite.
   task automatic busRead(input logic [3:0] a, output logic [31:0] d);
      @(negedge clk);
      bus_sel = 1'b1; bus_we = 1'b0; bus_addr = a;
      #1 d = bus_rdata;
      #1 bus_sel = 1'b0;
   endtask

   function automatic logic frameBit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
`ifdef CONSOLE_PARITY_EN
      if (k == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   task automatic addFrame(input logic [7:0] b, input int div);
      for (int k = 0; k < FRAME_BITS; k++)
         for (int c = 0; c < div; c++) expQ.push_back(frameBit(b, k));
   endtask

   // Index 0 is the first rising edge after the store that started the stream.
   task automatic checkStream(input int startIdx, input int stopIdx);
      for (int i = startIdx; i < stopIdx; i++) begin
         @(posedge clk); #1;
         total++;
         if (tx_o !== expQ[i] || tx_busy_o !== 1'b1) begin
            bad++;
            $display("FAIL stream[%0d]: tx=%b busy=%b, need tx=%b busy=1", i, tx_o, tx_busy_o, expQ[i]);
         end
      end
   endtask

   task automatic checkIdle(input string tag);
      @(posedge clk); #1;
      total++;
      if (tx_o !== 1'b1 || tx_busy_o !== 1'b0) begin
         bad++;
         $display("FAIL %s: tx=%b busy=%b, need tx=1 busy=0", tag, tx_o, tx_busy_o);
      end
   endtask

   task automatic checkReg(input string tag, input logic [3:0] a, input logic [31:0] need);
      logic [31:0] got;
      busRead(a, got);
      total++;
      if (got !== need) begin
         bad++;
         $display("FAIL %s: got %h, need %h", tag, got, need);
      end
   endtask

   task automatic test_reset;
      reset = 1'b0; bus_sel = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (tx_o !== 1'b1 || tx_busy_o !== 1'b0) begin
         bad++;
         $display("FAIL reset_outputs: tx=%b busy=%b, need tx=1 busy=0", tx_o, tx_busy_o);
      end
      @(negedge clk) reset = 1'b1;
      checkReg("reset_status", 4'h4, 32'h0000_0002);
      checkReg("reset_bauddiv", 4'h8, 32'h0000_01B2);
   endtask

   task automatic test_single_frame;
      busWrite(4'h8, 32'd4);
      expQ.delete();
      addFrame(8'hA5, 4);
      busWrite(4'h0, 32'h0000_00A5);
      checkStream(0, expQ.size());
      checkIdle("single_idle");
      checkReg("single_status", 4'h4, 32'h0000_0002);
   endtask

   task automatic test_overflow;
      busWrite(4'h8, 32'd2);
      expQ.delete();
      for (int v = 0; v <= 16; v++) addFrame(v[7:0], 2);
      // 0x00 leaves on the second edge, so the 18th store (0x11) is the one dropped.
      for (int v = 0; v <= 17; v++) busWrite(4'h0, v);
      checkReg("ovf_status_full", 4'h4, 32'h0000_100D);
      checkStream(17, expQ.size());
      checkIdle("ovf_idle");
      checkReg("ovf_sticky", 4'h4, 32'h0000_000A);
      busWrite(4'h4, 32'h0000_0008);
      checkReg("ovf_cleared", 4'h4, 32'h0000_0002);
   endtask

   task automatic test_bauddiv;
      busWrite(4'h8, 32'd0);
      checkReg("baud_zero", 4'h8, 32'h0000_0001);
      busWrite(4'h8, 32'h0001_2345);
      checkReg("baud_trunc", 4'h8, 32'h0000_2345);
      busWrite(4'hC, 32'hFFFF_FFFF);
      checkReg("baud_unmapped_write", 4'h8, 32'h0000_2345);
      checkReg("read_unmapped", 4'hC, 32'h0000_0000);
      checkReg("read_txdata", 4'h0, 32'h0000_0000);
      @(negedge clk);
      bus_sel = 1'b0; bus_addr = 4'h8;
      #1;
      total++;
      if (bus_rdata !== 32'h0) begin
         bad++;
         $display("FAIL rdata_unselected: got %h, need 00000000", bus_rdata);
      end
   endtask

   task automatic test_reset_mid_frame;
      busWrite(4'h8, 32'd4);
      expQ.delete();
      addFrame(8'h55, 4);
      busWrite(4'h0, 32'h0000_0055);
      checkStream(0, 11);
      #2 reset = 1'b0;
      #1;
      total++;
      if (tx_o !== 1'b1 || tx_busy_o !== 1'b0) begin
         bad++;
         $display("FAIL reset_abort: tx=%b busy=%b, need tx=1 busy=0", tx_o, tx_busy_o);
      end
      @(negedge clk) reset = 1'b1;
      checkReg("abort_status", 4'h4, 32'h0000_0002);
      checkReg("abort_bauddiv", 4'h8, 32'h0000_01B2);
      checkIdle("abort_idle");
   endtask

   task automatic test_div_change;
      busWrite(4'h8, 32'd4);
      expQ.delete();
      addFrame(8'h3C, 4);
      addFrame(8'hC3, 8);
      busWrite(4'h0, 32'h0000_003C);
      busWrite(4'h0, 32'h0000_00C3);
      busWrite(4'h8, 32'd8);
      checkStream(2, expQ.size());
      checkIdle("divchg_idle");
   endtask

`ifdef CONSOLE_PARITY_EN
   task automatic test_parity;
      busWrite(4'h8, 32'd3);
      expQ.delete();
      addFrame(8'h07, 3);
      busWrite(4'h0, 32'h0000_0007);
      checkStream(0, expQ.size());
      checkIdle("parity_idle");
   endtask
`endif

   initial begin
      test_reset();
      test_single_frame();
      test_overflow();
      test_bauddiv();
      test_reset_mid_frame();
      test_div_change();
`ifdef CONSOLE_PARITY_EN
      test_parity();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
